// File: rtl/sample_window_accum_pkg.sv
// sample_window_accum_pkg: shared widths, legal parameter bounds and FSM state type. Rev 1.0
`default_nettype none

package sample_window_accum_pkg;

  localparam int IN_W  = 8;
  localparam int CNT_W = 8;

  localparam int WINDOW_MIN = 1;
  localparam int WINDOW_MAX = 255;
  localparam int SUM_W_MIN  = 8;
  localparam int SUM_W_MAX  = 32;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } win_state_e;

endpackage

`default_nettype wire

// File: rtl/sample_window_accum_sat_add.sv
// sat_add: SUM_W-bit adder with carry-out; saturates under SAMPLE_WINDOW_ACCUM_SATURATE_EN. Rev 1.0
`default_nettype none

module sat_add
  import sample_window_accum_pkg::*;
#(
  parameter int SUM_W = 16
) (
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [SUM_W-1:0] sum,
  output logic             carry
);

  logic [SUM_W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[SUM_W];

`ifdef SAMPLE_WINDOW_ACCUM_SATURATE_EN
  // Once saturated, any further add also carries, so the sum stays pinned.
  assign sum = carry ? {SUM_W{1'b1}} : full[SUM_W-1:0];
`else
  assign sum = full[SUM_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/sample_window_accum.sv
// sample_window_accum: sums WINDOW samples and emits each sum on a registered valid/ready port.
// Saturating add and overflow reporting enabled by SAMPLE_WINDOW_ACCUM_SATURATE_EN. Rev 1.0
`default_nettype none

module sample_window_accum
  import sample_window_accum_pkg::*;
#(
  parameter int WINDOW = 4,
  parameter int SUM_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             flush,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

`ifdef SAMPLE_WINDOW_ACCUM_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  generate
    if (WINDOW < WINDOW_MIN || WINDOW > WINDOW_MAX ||
        SUM_W < SUM_W_MIN || SUM_W > SUM_W_MAX) begin : g_bad_params
      $error("sample_window_accum: WINDOW or SUM_W out of legal range");
    end
  endgenerate

  win_state_e       state, state_next;
  logic [SUM_W-1:0] acc, acc_next, acc_upd, add_sum, sample_ext;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_upd;
  logic             ovf, ovf_next, ovf_upd, add_carry;
  logic [SUM_W-1:0] sum_q, sum_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic             ovf_q, ovf_q_next;
  logic             ready_q;
  logic             accept;

  assign sample_ext = SUM_W'(in_data);

  sat_add #(.SUM_W(SUM_W)) u_sat_add (
    .a     (acc),
    .b     (sample_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign accept  = in_valid & ready_q;
  assign acc_upd = accept ? add_sum : acc;
  assign cnt_upd = accept ? cnt + CNT_W'(1) : cnt;
  assign ovf_upd = ovf | (accept & add_carry);

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    sum_next   = sum_q;
    count_next = count_q;
    ovf_q_next = ovf_q;
    if (clear) begin
      state_next = ACCUM;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
      sum_next   = '0;
      count_next = '0;
      ovf_q_next = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          acc_next = acc_upd;
          cnt_next = cnt_upd;
          ovf_next = ovf_upd;
          // A sample accepted alongside flush belongs to the closing window.
          if ((accept && cnt_upd == CNT_W'(WINDOW)) || (flush && cnt_upd != '0)) begin
            sum_next   = acc_upd;
            count_next = cnt_upd;
            ovf_q_next = ovf_upd;
            state_next = EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
            state_next = ACCUM;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      ovf     <= ovf_next;
      sum_q   <= sum_next;
      count_q <= count_next;
      ovf_q   <= ovf_q_next;
      ready_q <= (state_next == ACCUM);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state == EMIT);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign overflow  = ovf_q & SAT_EN;

endmodule

`default_nettype wire

// File: tb/tb_sample_window_accum.sv
// tb_sample_window_accum: directed self-checking bench for sample_window_accum. Rev 1.0
`default_nettype none

module tb_sample_window_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // DUT A: WINDOW=4, SUM_W=16
  logic        a_in_valid = 1'b0, a_flush = 1'b0, a_clear = 1'b0, a_out_ready = 1'b0;
  logic [7:0]  a_in_data = 8'd0;
  logic        a_in_ready, a_out_valid, a_overflow;
  logic [15:0] a_out_sum;
  logic [7:0]  a_out_count;

  // DUT B: WINDOW=2, SUM_W=8
  logic        b_in_valid = 1'b0, b_flush = 1'b0, b_clear = 1'b0, b_out_ready = 1'b0;
  logic [7:0]  b_in_data = 8'd0;
  logic        b_in_ready, b_out_valid, b_overflow;
  logic [7:0]  b_out_sum;
  logic [7:0]  b_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_window_accum #(.WINDOW(4), .SUM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .flush(a_flush), .clear(a_clear), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
    .overflow(a_overflow)
  );

  sample_window_accum #(.WINDOW(2), .SUM_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .flush(b_flush), .clear(b_clear), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
    .overflow(b_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({a_in_ready, a_out_valid, a_out_sum, a_out_count, a_overflow} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b expected all 0",
               a_in_ready, a_out_valid, a_out_sum, a_out_count, a_overflow);
    end
    #2 rst_n = 1'b1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge: got %b expected 0", a_in_ready);
    end
    step();
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got a=%b b=%b expected 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_window();
    a_out_ready = 1'b1;
    send_a(8'd10);
    send_a(8'd20);
    send_a(8'd30);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL win_early_valid: got %b expected 0", a_out_valid);
    end
    send_a(8'd40);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd100 || a_out_count !== 8'd4 ||
        a_overflow !== 1'b0 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL win_result: got vld=%b sum=%0d cnt=%0d ovf=%b rdy=%b expected 1 100 4 0 0",
               a_out_valid, a_out_sum, a_out_count, a_overflow, a_in_ready);
    end
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL win_return: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    send_a(8'd4);
    a_in_valid = 1'b1;
    a_in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 16'd10 || a_out_count !== 8'd4 ||
          a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b sum=%0d cnt=%0d rdy=%b expected 1 10 4 0",
                 i, a_out_valid, a_out_sum, a_out_count, a_in_ready);
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
    a_out_ready = 1'b0;
    send_a(8'd5);
    send_a(8'd5);
    send_a(8'd5);
    send_a(8'd5);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd20 || a_out_count !== 8'd4) begin
      errors++;
      $display("FAIL bp_next_window: got vld=%b sum=%0d cnt=%0d expected 1 20 4",
               a_out_valid, a_out_sum, a_out_count);
    end
    a_out_ready = 1'b1;
    step();
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    send_a(8'd7);
    send_a(8'd9);
    a_in_valid = 1'b1;
    a_in_data  = 8'd5;
    a_flush    = 1'b1;
    step();
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd21 || a_out_count !== 8'd3) begin
      errors++;
      $display("FAIL flush_result: got vld=%b sum=%0d cnt=%0d expected 1 21 3",
               a_out_valid, a_out_sum, a_out_count);
    end
    a_out_ready = 1'b1;
    step();
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_sum;
    logic       exp_ovf;
`ifdef SAMPLE_WINDOW_ACCUM_SATURATE_EN
    exp_sum = 8'd255;
    exp_ovf = 1'b1;
`else
    exp_sum = 8'd44;
    exp_ovf = 1'b0;
`endif
    b_out_ready = 1'b0;
    send_b(8'd200);
    send_b(8'd100);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_sum !== exp_sum || b_overflow !== exp_ovf ||
        b_out_count !== 8'd2) begin
      errors++;
      $display("FAIL ovf_result: got vld=%b sum=%0d ovf=%b cnt=%0d expected 1 %0d %b 2",
               b_out_valid, b_out_sum, b_overflow, b_out_count, exp_sum, exp_ovf);
    end
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    send_b(8'd1);
    send_b(8'd2);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_sum !== 8'd3 || b_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared: got vld=%b sum=%0d ovf=%b expected 1 3 0",
               b_out_valid, b_out_sum, b_overflow);
    end
    b_out_ready = 1'b1;
    step();
  endtask

  task automatic test_clear();
    a_out_ready = 1'b0;
    send_a(8'd1);
    send_a(8'd1);
    send_a(8'd1);
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_mid: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
    for (int i = 0; i < 4; i++) send_a(8'd1);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd4 || a_out_count !== 8'd4) begin
      errors++;
      $display("FAIL clear_window: got vld=%b sum=%0d cnt=%0d expected 1 4 4",
               a_out_valid, a_out_sum, a_out_count);
    end
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_sum !== 16'd0 || a_out_count !== 8'd0 ||
        a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_emit: got vld=%b sum=%0d cnt=%0d rdy=%b expected 0 0 0 1",
               a_out_valid, a_out_sum, a_out_count, a_in_ready);
    end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    send_a(8'd50);
    send_a(8'd60);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_mid_window: got rdy=%b vld=%b expected 0 0", a_in_ready, a_out_valid);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_ready: got %b expected 1", a_in_ready);
    end
    send_a(8'd10);
    send_a(8'd20);
    send_a(8'd30);
    send_a(8'd40);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd100 || a_out_count !== 8'd4) begin
      errors++;
      $display("FAIL areset_first_window: got vld=%b sum=%0d cnt=%0d expected 1 100 4",
               a_out_valid, a_out_sum, a_out_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_sum, a_out_count, a_overflow} !== 27'd0) begin
      errors++;
      $display("FAIL areset_mid_emit: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b expected all 0",
               a_in_ready, a_out_valid, a_out_sum, a_out_count, a_overflow);
    end
    #2 rst_n = 1'b1;
    step();
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    send_a(8'd4);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd10 || a_out_count !== 8'd4) begin
      errors++;
      $display("FAIL areset_after_emit: got vld=%b sum=%0d cnt=%0d expected 1 10 4",
               a_out_valid, a_out_sum, a_out_count);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_backpressure();
    test_flush();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_window_accum.md
# sample_window_accum

Windowed accumulator directly downstream of the 8-bit offset/bypass processing stage. It consumes that stage's `out_val` stream under a valid/ready handshake and sums WINDOW consecutive samples. It presents each window sum, with its sample count and an overflow flag, on a registered valid/ready output port. It is the first clocked stage after the combinational processing path.

## Interface
- `WINDOW`, default 4: samples per window; legal range 1..255.
- `SUM_W`, default 16: width of the accumulator and `out_sum`; legal range 8..32.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a sample this cycle.
- `in_data`  input  8  unsigned sample, from the processing stage's `out_val`.
- `flush`  input  1  close the current partial window early.
- `clear`  input  1  synchronous abort; discards all state.
- `out_valid`  output  1  `out_sum`, `out_count` and `overflow` are valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_sum`  output  SUM_W  window sum.
- `out_count`  output  8  number of samples in the window, 1..WINDOW.
- `overflow`  output  1  the window sum exceeded 2^SUM_W−1.

## Operation
- FSM states: ACCUM and EMIT. Reset state is ACCUM.
- **ACCUM**
  - `in_ready`=1 and `out_valid`=0.
  - Accept occurs when `in_valid`&`in_ready`. On accept, `acc` += zero-extended `in_data` and `cnt`++.
  - On the accept that makes `cnt`==WINDOW: latch the result registers and go to EMIT.
  - If `flush`=1 and the post-update `cnt`>0: latch the result registers and go to EMIT.
  - A sample accepted in the same cycle as `flush` is included in the emitted window.
  - `flush` with `cnt`==0 and no accept is ignored.
- **EMIT**
  - `in_ready`=0 and `out_valid`=1. The outputs hold stable until `out_ready`.
  - On handshake: `acc`=0, `cnt`=0, per-window overflow=0, then go to ACCUM.
  - `flush` is ignored in EMIT.
- **clear**
  - Has priority over all other events in every state.
  - Next cycle: ACCUM, `acc`=0, `cnt`=0, `out_valid`=0, and the result registers are zeroed.
  - An unacknowledged result is dropped.
- **Arithmetic**
  - `acc` is SUM_W bits wide. The add is computed SUM_W+1 bits wide.
  - The carry-out sets the per-window overflow bit, which is sticky until the window is emitted or cleared.
- **Reset values**
  - `in_ready`=0 while `rst_n`=0; it is 1 from the first cycle after deassertion.
  - All other outputs are 0: `out_valid`, `out_sum`, `out_count`, `overflow`.
  - Internal state: `acc`=0, `cnt`=0.

## Timing
- Latency: `out_valid` rises in the cycle after the accept that completes the window, or after the accept/flush cycle.
- Throughput: one sample per cycle in ACCUM. Each window costs a minimum of WINDOW accept cycles plus 1 EMIT cycle, because `in_ready` is 0 during the handshake cycle.
- All outputs are registered and `in_ready` is a decode of the state register. No combinational path exists from `out_ready` or `in_valid` to any output.
- Reset mid-window or mid-EMIT: state goes to reset values immediately; the partial window is lost.
- Once `out_valid`=1, `out_sum`, `out_count` and `overflow` do not change until handshake or clear.

## Configuration
- Macro: `SAMPLE_WINDOW_ACCUM_SATURATE_EN`.
- **Defined:** on carry-out, `acc` saturates to 2^SUM_W−1 and stays there for the rest of the window. `overflow` reports the sticky flag.
- **Undefined:** `acc` wraps modulo 2^SUM_W, and the `overflow` output is tied to 0. The port is still present.

## Structure
- Package `sample_window_accum_pkg` holds:
  - the state typedef `win_state_e` {ACCUM, EMIT};
  - `IN_W`=8 and `CNT_W`=8;
  - the legal range bounds for WINDOW and SUM_W, which the top checks in an elaboration-time assertion.
- One sub-module, `sat_add`: a parameterised SUM_W-bit adder that returns sum and carry. It contains the saturation mux under the macro.
- FSM, counter and result registers live in the top.

## Test plan
- **Window completes:** WINDOW=4; stream 10,20,30,40 back-to-back with `out_ready`=1 → `out_valid` one cycle after the 4th accept, `out_sum`=100, `out_count`=4, `overflow`=0; `in_ready` low for exactly 1 cycle.
- **Backpressure:** hold `out_ready`=0 for 5 cycles while EMIT → outputs stable, `in_ready`=0, `in_valid` samples not consumed; the next window starts only after the handshake.
- **Flush:** accept 7 and 9, then assert `flush` together with a third sample 5 → `out_sum`=21, `out_count`=3. A `flush` on an empty window produces no output.
- **Overflow:** SUM_W=8, WINDOW=2; send 200 then 100.
  - With the macro: `out_sum`=255, `overflow`=1.
  - Without it: `out_sum`=44, `overflow`=0.
- **Clear:** send 3 samples, then pulse `clear`; then send 4 samples of 1 → `out_sum`=4. A `clear` during EMIT drops `out_valid` in the next cycle.
- **Async reset:** drop `rst_n` mid-window and mid-EMIT (not aligned to `clk`) → all outputs 0 immediately; after release, `in_ready`=1 and the first window is correct.
